// File: rtl/uart_tx_framer.sv
// Single-frame buffer and packetizer that feeds uart_tx: SOF, length, payload, optional XOR checksum.
// Define UART_TX_FRAMER_CHECKSUM_EN to append the checksum byte (length XOR all payload bytes).
module uart_tx_framer #(
    parameter int         DEPTH    = 16,
    parameter logic [7:0] SOF_BYTE = 8'h7E
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Wr_DV,
    input  logic [7:0] i_Wr_Byte,
    input  logic       i_Commit,
    output logic       o_Ready,
    output logic       o_Overflow,
    output logic       o_Frame_Done,
    output logic       o_Tx_DV,
    output logic [7:0] o_Tx_Byte,
    input  logic       i_Tx_Active,
    input  logic       i_Tx_Done,
    output logic [2:0] o_State
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] S_FILL = 3'd0;
    localparam logic [2:0] S_SOF  = 3'd1;
    localparam logic [2:0] S_LEN  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd4;
`endif

    localparam logic PH_ISSUE = 1'b0;
    localparam logic PH_WAIT  = 1'b1;

    // Handshake with uart_tx: o_Tx_DV is a 1-cycle pulse issued only while Active=0 and Done=0;
    // o_Tx_Byte holds from that pulse until the byte completes, which is the first rising edge of
    // i_Tx_Done after i_Tx_Active has been seen high.
    logic [2:0]    state;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_idx;
    logic          phase;
    logic          seen_active;
    logic          done_q;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          overflow;
    logic          frame_done;
    logic [7:0]    mem [0:(1<<AW)-1];
`ifdef UART_TX_FRAMER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    logic          wr_accept;
    logic          wr_drop;
    logic          commit_go;
    logic          can_issue;
    logic          byte_done;
    logic          last_data;
    logic [7:0]    len_byte;
    logic [7:0]    field_byte;

    always_comb begin
        wr_accept = (state == S_FILL) && i_Wr_DV && (count < CW'(DEPTH));
        wr_drop   = (state == S_FILL) && i_Wr_DV && (count == CW'(DEPTH));
        commit_go = (state == S_FILL) && i_Commit && ((count != '0) || wr_accept);
        can_issue = (state != S_FILL) && (phase == PH_ISSUE) && !i_Tx_Active && !i_Tx_Done;
        byte_done = (state != S_FILL) && (phase == PH_WAIT) && (seen_active || i_Tx_Active)
                    && i_Tx_Done && !done_q;
        last_data = ((CW'(rd_idx) + CW'(1)) == count);
        len_byte  = 8'(count);
        field_byte = 8'h00;
        case (state)
            S_SOF:  field_byte = SOF_BYTE;
            S_LEN:  field_byte = len_byte;
            S_DATA: field_byte = mem[rd_idx];
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            S_CSUM: field_byte = csum;
`endif
            default: field_byte = 8'h00;
        endcase
    end

    // Payload storage carries no reset; count alone decides which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (wr_accept) begin
            mem[count[AW-1:0]] <= i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= S_FILL;
            count       <= '0;
            rd_idx      <= '0;
            phase       <= PH_ISSUE;
            seen_active <= 1'b0;
            done_q      <= 1'b0;
            tx_dv       <= 1'b0;
            tx_byte     <= 8'h00;
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            csum        <= 8'h00;
`endif
        end else begin
            tx_dv      <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            done_q     <= i_Tx_Done;
            if (state == S_FILL) begin
                if (wr_accept) begin
                    count <= count + CW'(1);
                end
                if (wr_drop) begin
                    overflow <= 1'b1;
                end
                if (commit_go) begin
                    state       <= S_SOF;
                    phase       <= PH_ISSUE;
                    seen_active <= 1'b0;
                    rd_idx      <= '0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
                    csum        <= 8'h00;
`endif
                end
            end else if (can_issue) begin
                tx_dv       <= 1'b1;
                tx_byte     <= field_byte;
                phase       <= PH_WAIT;
                seen_active <= 1'b0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
                if ((state == S_LEN) || (state == S_DATA)) begin
                    csum <= csum ^ field_byte;
                end
`endif
            end else if (phase == PH_WAIT) begin
                if (i_Tx_Active) begin
                    seen_active <= 1'b1;
                end
                if (byte_done) begin
                    phase       <= PH_ISSUE;
                    seen_active <= 1'b0;
                    case (state)
                        S_SOF: state <= S_LEN;
                        S_LEN: state <= S_DATA;
                        S_DATA: begin
                            if (last_data) begin
`ifdef UART_TX_FRAMER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state      <= S_FILL;
                                count      <= '0;
                                frame_done <= 1'b1;
`endif
                            end else begin
                                rd_idx <= rd_idx + AW'(1);
                            end
                        end
                        default: begin
                            // Checksum byte (or an illegal encoding) ends the frame.
                            state      <= S_FILL;
                            count      <= '0;
                            frame_done <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign o_Ready      = (state == S_FILL);
    assign o_Overflow   = overflow;
    assign o_Frame_Done = frame_done;
    assign o_Tx_DV      = tx_dv;
    assign o_Tx_Byte    = tx_byte;
    assign o_State      = state;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with a behavioural uart_tx model capturing every issued byte.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_dv = 1'b0;
    logic [7:0] wr_byte = 8'h00;
    logic       commit = 1'b0;
    logic       tx_active = 1'b0;
    logic       tx_done = 1'b0;
    logic       ready, ovf, fdone, tx_dv;
    logic [7:0] tx_byte;
    logic [2:0] st;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int fd_cnt = 0;
    int ovf_cnt = 0;
    int viol_cnt = 0;
    int rdy_bad = 0;
    int done_hold = 1;
    int bit_left = 0;
    int done_left = 0;

    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];

    always #5 clk = ~clk;

    uart_tx_framer #(.DEPTH(16), .SOF_BYTE(8'h7E)) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Wr_DV      (wr_dv),
        .i_Wr_Byte    (wr_byte),
        .i_Commit     (commit),
        .o_Ready      (ready),
        .o_Overflow   (ovf),
        .o_Frame_Done (fdone),
        .o_Tx_DV      (tx_dv),
        .o_Tx_Byte    (tx_byte),
        .i_Tx_Active  (tx_active),
        .i_Tx_Done    (tx_done),
        .o_State      (st)
    );

    // uart_tx model: Active for 4 cycles after DV, then Done for done_hold cycles; ignores reset.
    always @(negedge clk) begin
        if (fdone) begin
            fd_cnt++;
            if (!ready) rdy_bad++;
        end
        if (ovf) ovf_cnt++;
        if (tx_dv && (tx_active || tx_done)) viol_cnt++;
        if (done_left > 0) begin
            done_left--;
            if (done_left == 0) tx_done = 1'b0;
        end else if (tx_active) begin
            bit_left--;
            if (bit_left == 0) begin
                tx_active = 1'b0;
                tx_done   = 1'b1;
                done_left = done_hold;
            end
        end else if (tx_dv) begin
            tx_active = 1'b1;
            bit_left  = 4;
            cap_q.push_back(tx_byte);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_dv = 1'b1;
        wr_byte = b;
        tick();
        wr_dv = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int start;
        int n;
        start = fd_cnt;
        n = 0;
        while (fd_cnt == start && n < 3000) begin
            tick();
            n++;
        end
        check(tag, fd_cnt - start, 1);
        ticks(3);
    endtask

    task automatic build_exp();
        logic [7:0] cs;
        exp_q.delete();
        exp_q.push_back(8'h7E);
        exp_q.push_back(8'(pay_q.size()));
        cs = 8'(pay_q.size());
        foreach (pay_q[i]) begin
            exp_q.push_back(pay_q[i]);
            cs = cs ^ pay_q[i];
        end
`ifdef UART_TX_FRAMER_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic check_frame(input string tag);
        build_exp();
        check({tag, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), cap_q[i], exp_q[i]);
        end
    endtask

    initial begin
        int n;
        int ovf0;

        // Reset
        ticks(3);
        rst = 1'b0;
        tick();
        check("rst_ready", ready, 1);
        check("rst_ovf", ovf, 0);
        check("rst_fdone", fdone, 0);
        check("rst_txdv", tx_dv, 0);
        check("rst_txbyte", tx_byte, 0);
        check("rst_state", st, 0);

        // Two-byte frame: 7E 02 A5 3C
        cap_q.delete();
        write_byte(8'hA5);
        write_byte(8'h3C);
        do_commit();
        check("t1_busy", ready, 0);
        wait_frame("t1_done");
        pay_q = '{8'hA5, 8'h3C};
        check_frame("t1");
        check("t1_fdone_cnt", fd_cnt, 1);
        check("t1_ready", ready, 1);

        // Empty commit is ignored; write+commit in one cycle includes the byte
        cap_q.delete();
        do_commit();
        ticks(20);
        check("t3_empty_nodv", cap_q.size(), 0);
        check("t3_empty_ready", ready, 1);
        wr_dv = 1'b1;
        wr_byte = 8'h11;
        commit = 1'b1;
        tick();
        wr_dv = 1'b0;
        commit = 1'b0;
        wait_frame("t3_done");
        pay_q = '{8'h11};
        check_frame("t3");

        // Overflow on the 17th write only; frame carries the first 16
        cap_q.delete();
        ovf0 = ovf_cnt;
        pay_q.delete();
        for (int i = 0; i < 16; i++) begin
            write_byte(8'h20 + 8'(i));
            pay_q.push_back(8'h20 + 8'(i));
        end
        ticks(2);
        check("t2_no_ovf_16", ovf_cnt - ovf0, 0);
        write_byte(8'hFF);
        ticks(2);
        check("t2_ovf_17", ovf_cnt - ovf0, 1);
        do_commit();
        wait_frame("t2_done");
        check_frame("t2");

        // Done held two cycles per byte
        cap_q.delete();
        done_hold = 2;
        write_byte(8'hC3);
        write_byte(8'h3C);
        do_commit();
        wait_frame("t4_done");
        pay_q = '{8'hC3, 8'h3C};
        check_frame("t4");
        done_hold = 1;

        // Writes and commit during a frame are ignored
        cap_q.delete();
        ovf0 = ovf_cnt;
        write_byte(8'h10);
        write_byte(8'h20);
        do_commit();
        ticks(3);
        check("t5_not_ready", ready, 0);
        wr_dv = 1'b1;
        wr_byte = 8'hEE;
        commit = 1'b1;
        ticks(5);
        wr_dv = 1'b0;
        commit = 1'b0;
        check("t5_no_ovf", ovf_cnt - ovf0, 0);
        wait_frame("t5_done");
        pay_q = '{8'h10, 8'h20};
        check_frame("t5");
        cap_q.delete();
        do_commit();
        ticks(20);
        check("t5_count_clear", cap_q.size(), 0);
        write_byte(8'h55);
        do_commit();
        wait_frame("t5b_done");
        pay_q = '{8'h55};
        check_frame("t5b");

        // Reset in the middle of the payload
        cap_q.delete();
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        do_commit();
        n = 0;
        while (st != 3'd3 && n < 500) begin
            tick();
            n++;
        end
        check("t6_reach_data", st, 3);
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_txdv", tx_dv, 0);
        check("t6_rst_state", st, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_ready", ready, 1);
        check("t6_txdv", tx_dv, 0);
        n = 0;
        while ((tx_active || tx_done) && n < 200) begin
            tick();
            n++;
        end
        cap_q.delete();
        do_commit();
        ticks(20);
        check("t6_count_zero", cap_q.size(), 0);
        write_byte(8'h9A);
        write_byte(8'h5B);
        do_commit();
        wait_frame("t6_done");
        pay_q = '{8'h9A, 8'h5B};
        check_frame("t6");

        check("no_dv_while_busy", viol_cnt, 0);
        check("ready_with_fdone", rdy_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
